// File: rtl/md_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
//   md_op_e    : md_op encodings driven by the E stage
//   md_state_e : scheduler FSM states
//   MULT_LAT_DEF / DIV_LAT_DEF : default commit latencies
//   md_cnt_w() : latency counter width for a given latency pair
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // Counter must hold the larger latency value itself.
  function automatic int md_cnt_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational mult/div datapath.
//   op     : md_op (mult/multu/div/divu produce results, others give 0)
//   rs, rt : operands (rs = dividend / multiplicand, rt = divisor / multiplier)
//   res_hi : product[63:32] or remainder
//   res_lo : product[31:0]  or quotient
// Signed ops run on magnitudes and re-apply the sign afterwards, so one
// unsigned multiplier and one unsigned divider serve both flavours.
module md_compute
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic        sgn;
  logic        neg_res;
  logic [31:0] a_mag, b_mag, dvs, q_mag, r_mag;
  logic [63:0] prod;

  always_comb begin
    sgn     = (op == MD_MULT) || (op == MD_DIV);
    a_mag   = (sgn && rs[31]) ? -rs : rs;
    b_mag   = (sgn && rt[31]) ? -rt : rt;
    neg_res = sgn && (rs[31] ^ rt[31]);

    prod = {32'b0, a_mag} * {32'b0, b_mag};
    if (neg_res) prod = -prod;

    // Divide-by-zero result is discarded by the controller; avoid /0 here.
    dvs   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / dvs;
    r_mag = a_mag % dvs;

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT, MD_MULTU: {res_hi, res_lo} = prod;
      MD_DIV, MD_DIVU: begin
        // quotient truncates toward zero, remainder takes dividend sign
        res_lo = neg_res ? -q_mag : q_mag;
        res_hi = (sgn && rs[31]) ? -r_mag : r_mag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_md_ctrl.sv
// Execute-stage multiply/divide scheduler owning HI/LO.
//   clk, rst_n : clock, async active-low reset
//   md_start   : E-stage md op valid this cycle
//   md_op      : operation (md_pkg encodings)
//   rs_val     : dividend / multiplicand / mthi-mtlo source
//   rt_val     : divisor / multiplier
//   d_is_md    : D-stage instruction touches HI/LO
//   hi, lo     : architectural HI/LO registers
//   busy       : mult/div in flight
//   md_stall   : freeze F/D, bubble E
// Results are computed at accept and parked in pend_hi/pend_lo; the counter
// only models latency. HI/LO change only at the commit edge.
module e_md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  localparam int CW = md_cnt_w(MULT_LAT, DIV_LAT);

  md_state_e   state, state_nxt;
  logic [CW-1:0] count;
  logic [31:0] pend_hi, pend_lo;
  logic [31:0] res_hi, res_lo;
  logic        is_muldiv, is_div, accept, commit;

  md_compute u_compute (
    .op     (md_op),
    .rs     (rs_val),
    .rt     (rt_val),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign is_muldiv = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                     (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign is_div    = (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign accept    = (state == IDLE) && md_start && is_muldiv;
  assign commit    = (state == BUSY) && (count == CW'(1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (commit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy     = (state == BUSY);
    md_stall = d_is_md && (busy || (md_start && is_muldiv));
  end

  // counter, pending results, HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept) begin
      count <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      // Divide by zero still burns full latency but commits the old HI/LO back.
      if (is_div && rt_val == 32'd0) begin
        pend_hi <= hi;
        pend_lo <= lo;
      end else begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
      end
    end else if (state == BUSY) begin
      count <= count - CW'(1);
      if (commit) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (md_start) begin
      if (md_op == MD_MTHI) hi <= rs_val;
      if (md_op == MD_MTLO) lo <= rs_val;
    end
  end

endmodule
